// File: rtl/ysyx_25020037_axi_pkg.sv
// rtl/ysyx_25020037_axi_pkg.sv - AXI response/burst codes, CLINT map and responder FSM encoding
package ysyx_25020037_axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [31:0] CLINT_BASE   = 32'h0200_0000;
   localparam logic [2:0]  MTIME_LO_OFF = 3'h0;
   localparam logic [2:0]  MTIME_HI_OFF = 3'h4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   // Burst-type and size errors outrank address decode errors.
   function automatic logic [1:0] beat_resp(input logic [1:0]  burst,
                                            input logic [2:0]  size,
                                            input logic [31:0] addr,
                                            input logic [31:0] base);
      logic [1:0] resp;
      if (burst == BURST_WRAP || burst == 2'b11)
         resp = RESP_SLVERR;
      else if (size > 3'd2)
         resp = RESP_SLVERR;
      else if (addr[31:3] != base[31:3])
         resp = RESP_DECERR;
      else if (addr[2:0] != MTIME_LO_OFF && addr[2:0] != MTIME_HI_OFF)
         resp = RESP_DECERR;
      else
         resp = RESP_OKAY;
      return resp;
   endfunction

endpackage

// File: rtl/ysyx_25020037_clint_if.sv
// rtl/ysyx_25020037_clint_if.sv - AXI4 read-only AR/R channel bundle for the CLINT responder
interface ysyx_25020037_clint_if;

   logic        arready;
   logic        arvalid;
   logic [31:0] araddr;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rready;
   logic        rvalid;
   logic [1:0]  rresp;
   logic [31:0] rdata;
   logic        rlast;
   logic [3:0]  rid;

   modport master (
      output arvalid, araddr, arid, arlen, arsize, arburst, rready,
      input  arready, rvalid, rresp, rdata, rlast, rid
   );

   modport slave (
      input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
      output arready, rvalid, rresp, rdata, rlast, rid
   );

endinterface

// File: rtl/ysyx_25020037_clint_mtime.sv
// rtl/ysyx_25020037_clint_mtime.sv - prescaled free-running 64-bit mtime counter
module ysyx_25020037_clint_mtime #(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [63:0] mtime
);

   localparam int unsigned   PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);

   logic [PW-1:0] pre_q;
   logic [63:0]   cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q <= '0;
         cnt_q <= '0;
      end else if (pre_q == PRE_TOP) begin
         pre_q <= '0;
         cnt_q <= cnt_q + 64'd1;
      end else begin
         pre_q <= pre_q + PW'(1);
      end
   end

   assign mtime = cnt_q;

endmodule

// File: rtl/ysyx_25020037_clint.sv
// rtl/ysyx_25020037_clint.sv - AXI4 read-only CLINT responder returning a snapshotted mtime
module ysyx_25020037_clint
   import ysyx_25020037_axi_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = CLINT_BASE,
   parameter int unsigned TICK_DIV   = 1,
   parameter int unsigned RD_LATENCY = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   ysyx_25020037_clint_if.slave  axi,
   output logic [63:0]           mtime_o
);

   localparam logic [3:0] WAIT_LOAD = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;

   logic [63:0] mtime;

   ysyx_25020037_clint_mtime #(.TICK_DIV(TICK_DIV)) u_mtime (
      .clk   (clk),
      .rst   (rst),
      .mtime (mtime)
   );

   assign mtime_o = mtime;

   logic [1:0]  state;
   logic [31:0] addr_q;
   logic [3:0]  id_q;
   logic [7:0]  len_q;
   logic [7:0]  beat_q;
   logic [2:0]  size_q;
   logic [1:0]  burst_q;
   logic [63:0] snap;
   logic [3:0]  wait_cnt;
   logic        arready_q;
   logic        rvalid_q;
   logic        rlast_q;
   logic [1:0]  rresp_q;
   logic [31:0] rdata_q;
   logic [3:0]  rid_q;

   // Beat to load into R: the current one while R is empty, else the one after the accepted beat.
   logic [31:0] adv_addr;
   logic [31:0] sel_addr;
   logic [7:0]  sel_beat;
   logic [1:0]  sel_resp;
   logic [31:0] sel_data;

   always_comb begin
      adv_addr = (burst_q == BURST_FIXED) ? addr_q : addr_q + 32'd4;
      sel_addr = rvalid_q ? adv_addr : addr_q;
      sel_beat = rvalid_q ? beat_q + 8'd1 : beat_q;
      sel_resp = beat_resp(burst_q, size_q, sel_addr, BASE_ADDR);
      sel_data = 32'd0;
      if (sel_resp == RESP_OKAY)
         sel_data = sel_addr[2] ? snap[63:32] : snap[31:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         id_q      <= '0;
         len_q     <= '0;
         beat_q    <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         snap      <= '0;
         wait_cnt  <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
         rid_q     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (arready_q && axi.arvalid) begin
                  addr_q    <= axi.araddr;
                  id_q      <= axi.arid;
                  len_q     <= axi.arlen;
                  size_q    <= axi.arsize;
                  burst_q   <= axi.arburst;
                  snap      <= mtime;
                  beat_q    <= 8'd0;
                  arready_q <= 1'b0;
                  if (RD_LATENCY > 0) begin
                     wait_cnt <= WAIT_LOAD;
                     state    <= ST_WAIT;
                  end else begin
                     state    <= ST_DATA;
                  end
               end else begin
                  arready_q <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == 4'd0)
                  state <= ST_DATA;
               else
                  wait_cnt <= wait_cnt - 4'd1;
            end
            ST_DATA: begin
               if (!rvalid_q || axi.rready) begin
                  if (rvalid_q && rlast_q) begin
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     arready_q <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     if (rvalid_q) begin
                        beat_q <= sel_beat;
                        addr_q <= adv_addr;
                     end
                     rvalid_q <= 1'b1;
                     rdata_q  <= sel_data;
                     rresp_q  <= sel_resp;
                     rlast_q  <= (sel_beat == len_q);
                     rid_q    <= id_q;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign axi.arready = arready_q;
   assign axi.rvalid  = rvalid_q;
   assign axi.rlast   = rlast_q;
   assign axi.rresp   = rresp_q;
   assign axi.rdata   = rdata_q;
   assign axi.rid     = rid_q;

endmodule
